// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end.
//   pc_t / inst_t   : default-width PC and instruction words
//   fq_entry_t      : one queued fetch {pc, inst}
//   FQ_DEPTH        : default queue depth
//   fq_count_t      : occupancy counter sized for FQ_DEPTH
//   redir_state_t   : branch-redirect tracking state
package fetch_queue_pkg;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned FQ_DEPTH   = 4;

  typedef logic [PC_WIDTH-1:0]   pc_t;
  typedef logic [INST_WIDTH-1:0] inst_t;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } fq_entry_t;

  typedef logic [$clog2(FQ_DEPTH+1)-1:0] fq_count_t;

  // REDIR_DELAY_SLOT: the delay slot still has to be fetched before the
  // stored branch target can be issued.
  typedef enum logic {
    REDIR_NONE,
    REDIR_DELAY_SLOT
  } redir_state_t;

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer holding fetched {pc, inst} entries.
//   clk, rst    : clock, asynchronous active-low reset
//   push        : write push_data at the tail
//   pop         : retire the head entry
//   keep_next   : retire the head and keep only the entry behind it
//   clear       : empty the buffer (highest priority)
//   head        : head entry, read straight from storage
//   count       : occupancy (0..DEPTH)
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  input  logic                         keep_next,
  input  logic                         clear,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (keep_next) begin
      // Tail is rewound to just behind the new head; younger entries vanish.
      assert (count >= CW'(2));
      rd_ptr <= rd_ptr + AW'(1);
      wr_ptr <= rd_ptr + AW'(2);
      count  <= CW'(1);
    end else begin
      assert (!(push && !pop && count == CW'(DEPTH)));
      assert (!(pop && count == '0));
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential ROM reads, queues the
// returned instructions with their PCs and hands them to IF/ID.
//   clk, rst              : clock, asynchronous active-low reset
//   rom_ce, rom_addr      : ROM read request / address
//   rom_data              : ROM data, one cycle after rom_ce
//   valid_o, pc_o, inst_o : head entry towards IF/ID
//   stall_i               : IF/ID not accepting the head
//   jump_i, jump_target_i : taken branch on the dequeued instruction
//   flush_i, flush_pc_i   : discard everything, restart at flush_pc_i
//   count_o               : queue occupancy
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = FQ_DEPTH,
  parameter int unsigned     PC_W     = PC_WIDTH,
  parameter int unsigned     INST_W   = INST_WIDTH,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_ce,
  output logic [PC_W-1:0]            rom_addr,
  input  logic [INST_W-1:0]          rom_data,
  output logic                       valid_o,
  output logic [PC_W-1:0]            pc_o,
  output logic [INST_W-1:0]          inst_o,
  input  logic                       stall_i,
  input  logic                       jump_i,
  input  logic [PC_W-1:0]            jump_target_i,
  input  logic                       flush_i,
  input  logic [PC_W-1:0]            flush_pc_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PC_W-1:0]        fetch_pc, fetch_pc_nxt;
  logic [PC_W-1:0]        inflight_pc;
  logic [PC_W-1:0]        redir_target, redir_target_nxt;
  logic                   inflight, inflight_nxt;
  redir_state_t           redir, redir_nxt;
  logic                   deq, jmp, jmp_keep_next, jmp_need_slot;
  logic                   issue, push;
  logic [CW:0]            occupancy;
  logic [PC_W+INST_W-1:0] head;

  assign valid_o = (count_o != '0);
  assign deq     = valid_o && !stall_i;
  assign jmp     = jump_i && deq && !flush_i;

  // Delay slot already queued behind the branch: keep it, drop the rest.
  assign jmp_keep_next = jmp && (count_o > CW'(1));
  // Branch is alone and nothing is returning: the delay slot must be fetched.
  assign jmp_need_slot = jmp && (count_o == CW'(1)) && !inflight;

  assign occupancy = {1'b0, count_o} + (CW+1)'(inflight);

  // No issue in jump/flush cycles: fetch_pc is on the wrong path there.
  assign issue  = rst && !flush_i && !jmp && (occupancy < (CW+1)'(DEPTH));
  assign push   = inflight && !flush_i && !jmp_keep_next;
  assign rom_ce   = issue;
  assign rom_addr = fetch_pc;

  assign pc_o   = head[INST_W +: PC_W];
  assign inst_o = head[INST_W-1:0];

  fq_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({inflight_pc, rom_data}),
    .pop       (deq),
    .keep_next (jmp_keep_next),
    .clear     (flush_i),
    .head      (head),
    .count     (count_o)
  );

  always_comb begin
    fetch_pc_nxt     = fetch_pc;
    redir_nxt        = redir;
    redir_target_nxt = redir_target;
    inflight_nxt     = issue;
    if (flush_i) begin
      fetch_pc_nxt = flush_pc_i;
      redir_nxt    = REDIR_NONE;
    end else if (jmp) begin
      if (jmp_need_slot) begin
        fetch_pc_nxt     = pc_o + PC_W'(PC_STEP);
        redir_nxt        = REDIR_DELAY_SLOT;
        redir_target_nxt = jump_target_i;
      end else begin
        fetch_pc_nxt = jump_target_i;
        redir_nxt    = REDIR_NONE;
      end
    end else if (issue) begin
      if (redir == REDIR_DELAY_SLOT) begin
        fetch_pc_nxt = redir_target;
        redir_nxt    = REDIR_NONE;
      end else begin
        fetch_pc_nxt = fetch_pc + PC_W'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc     <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      redir        <= REDIR_NONE;
      redir_target <= '0;
    end else begin
      fetch_pc     <= fetch_pc_nxt;
      inflight     <= inflight_nxt;
      inflight_pc  <= fetch_pc;
      redir        <= redir_nxt;
      redir_target <= redir_target_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  pc_t         rom_addr;
  inst_t       rom_data;
  logic        valid_o;
  pc_t         pc_o;
  inst_t       inst_o;
  logic        stall_i;
  logic        jump_i;
  pc_t         jump_target_i;
  logic        flush_i;
  pc_t         flush_pc_i;
  logic [2:0]  count_o;

  fetch_queue #(
    .DEPTH    (4),
    .PC_W     (32),
    .INST_W   (32),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .stall_i       (stall_i),
    .jump_i        (jump_i),
    .jump_target_i (jump_target_i),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .count_o       (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: returns addr>>2 one cycle after the request.
  initial rom_data = '0;
  always @(posedge clk) if (rom_ce) rom_data <= rom_addr >> 2;

  typedef struct {
    bit   st, jp, fl;
    pc_t  jt, fp;
    bit   ev;
    pc_t  ep;
    bit   ec;
    pc_t  ea;
    int   ecnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input bit st, input bit jp, input pc_t jt, input bit fl, input pc_t fp,
                     input bit ev, input pc_t ep, input bit ec, input pc_t ea, input int ecnt);
    vec_t v;
    v.st = st; v.jp = jp; v.jt = jt; v.fl = fl; v.fp = fp;
    v.ev = ev; v.ep = ep; v.ec = ec; v.ea = ea; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  // zero=1 additionally requires pc_o/inst_o to be 0 (reset values).
  task automatic check(input string name, input bit ev, input pc_t ep, input bit ec,
                       input pc_t ea, input int ecnt, input bit zero);
    bit bad;
    pc_t ei;
    bad = 1'b0;
    ei  = ep >> 2;
    n_vec++;
    if (valid_o !== ev) bad = 1'b1;
    if (ev && (pc_o !== ep || inst_o !== ei)) bad = 1'b1;
    if (zero && (pc_o !== '0 || inst_o !== '0)) bad = 1'b1;
    if (rom_ce !== ec || rom_addr !== ea) bad = 1'b1;
    if (int'(count_o) != ecnt) bad = 1'b1;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b pc=%h inst=%h ce=%0b addr=%h cnt=%0d, want valid=%0b pc=%h ce=%0b addr=%h cnt=%0d",
               name, valid_o, pc_o, inst_o, rom_ce, rom_addr, count_o, ev, ep, ec, ea, ecnt);
    end
  endtask

  initial begin
    rst = 1'b0; stall_i = 1'b0; jump_i = 1'b0; flush_i = 1'b0;
    jump_target_i = '0; flush_pc_i = '0;

    //   st jp  jt       fl fp        ev ep        ce addr      cnt
    // sequential start-up, one instruction per cycle
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h00,  0); // 0
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h04,  0);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h00,  1, 32'h08,  1);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h04,  1, 32'h0C,  1);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h08,  1, 32'h10,  1);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h0C,  1, 32'h14,  1); // 5
    // 10-cycle stall: fill to DEPTH, then no requests, head frozen
    add(1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  1, 32'h18,  1);
    add(1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  1, 32'h1C,  2);
    add(1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  0, 32'h20,  3);
    for (int i = 0; i < 7; i++)
      add(1, 0, 32'h0, 0, 32'h0,   1, 32'h10,  0, 32'h20,  4); // 9..15
    // release: drain in order, fetching resumes at 0x20
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h10,  0, 32'h20,  4); // 16
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h14,  1, 32'h20,  3);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h18,  1, 32'h24,  2);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h1C,  1, 32'h28,  2);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h20,  1, 32'h2C,  2);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h24,  1, 32'h30,  2);
    // flush to 0x10, build queue 0x10,0x14,0x18 (+0x1C in flight)
    add(0, 0, 32'h0,   1, 32'h10,  1, 32'h28,  0, 32'h34,  2); // 22
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h10,  0);
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h14,  0);
    add(1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  1, 32'h18,  1);
    add(1, 0, 32'h0,   0, 32'h0,   1, 32'h10,  1, 32'h1C,  2);
    // jump case (a): branch 0x10 -> 0x100, keep 0x14, drop 0x18/0x1C
    add(0, 1, 32'h100, 0, 32'h0,   1, 32'h10,  0, 32'h20,  3); // 27
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h14,  1, 32'h100, 1);
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h104, 0);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 1, 32'h108, 1);
    // flush to 0x08, queue 0x08,0x0C,0x10,0x14
    add(0, 0, 32'h0,   1, 32'h08,  1, 32'h104, 0, 32'h10C, 1); // 31
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h08,  0);
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h0C,  0);
    add(1, 0, 32'h0,   0, 32'h0,   1, 32'h08,  1, 32'h10,  1);
    add(1, 0, 32'h0,   0, 32'h0,   1, 32'h08,  1, 32'h14,  2);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h08,  0, 32'h18,  3);
    // case (a) at 0x0C leaves only 0x10, nothing in flight
    add(0, 1, 32'h300, 0, 32'h0,   1, 32'h0C,  0, 32'h18,  3); // 37
    // case (c): branch 0x10 -> 0x200: fetch 0x14, then 0x200
    add(0, 1, 32'h200, 0, 32'h0,   1, 32'h10,  0, 32'h300, 1); // 38
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h14,  0);
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 0);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h14,  1, 32'h204, 1);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 1, 32'h208, 1);
    // case (b): branch 0x204 alone, 0x208 in flight is the delay slot
    add(0, 1, 32'h280, 0, 32'h0,   1, 32'h204, 0, 32'h20C, 1); // 43
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h208, 1, 32'h280, 1);
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h284, 0);
    add(1, 0, 32'h0,   0, 32'h0,   1, 32'h280, 1, 32'h288, 1);
    add(1, 0, 32'h0,   0, 32'h0,   1, 32'h280, 1, 32'h28C, 2);
    // flush + jump together with queue+inflight full: flush wins
    add(0, 1, 32'h100, 1, 32'h380, 1, 32'h280, 0, 32'h290, 3); // 48
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h380, 0);
    add(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h384, 0);
    add(0, 0, 32'h0,   0, 32'h0,   1, 32'h380, 1, 32'h388, 1); // 51

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 0, 32'h0, 0, 32'h0, 0, 1);
    rst = 1'b1;

    foreach (vecs[i]) begin
      stall_i       = vecs[i].st;
      jump_i        = vecs[i].jp;
      jump_target_i = vecs[i].jt;
      flush_i       = vecs[i].fl;
      flush_pc_i    = vecs[i].fp;
      #4;
      check($sformatf("row%0d", i), vecs[i].ev, vecs[i].ep, vecs[i].ec, vecs[i].ea, vecs[i].ecnt, 0);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-stream with 0x388 in flight.
    stall_i = 1'b0; jump_i = 1'b0; flush_i = 1'b0;
    jump_target_i = '0; flush_pc_i = '0;
    #2 rst = 1'b0;
    #1 check("async_reset", 0, 32'h0, 0, 32'h0, 0, 1);
    #3 rst = 1'b1;
    #1 check("reset_release", 0, 32'h0, 1, 32'h0, 0, 1);
    @(posedge clk); #4;
    check("post_reset_1", 0, 32'h0, 1, 32'h4, 0, 0);
    @(posedge clk); #4;
    check("post_reset_2", 1, 32'h0, 1, 32'h8, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end replacing the single-register PC/IF path between instruction ROM and the IF/ID stage.
- Issues sequential ROM reads, buffers returned instructions with their PCs in a DEPTH-entry queue, and presents them to the decoder through a valid/stall handshake.
- Handles branch redirects with MIPS delay-slot preservation, and full pipeline flushes for exceptions.

Parameters:
DEPTH, 4, queue entries (power of two, ≥2)
PC_W, 32, PC/ROM address width
INST_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
rom_ce  output  1  ROM chip enable / read request
rom_addr  output  PC_W  ROM read address
rom_data  input  INST_W  ROM read data, valid exactly one cycle after rom_ce=1
valid_o  output  1  head entry available to IF/ID
pc_o  output  PC_W  PC of head entry
inst_o  output  INST_W  instruction of head entry
stall_i  input  1  IF/ID not accepting (stall bit from ctrl); deq = valid_o && !stall_i
jump_i  input  1  branch taken; legal only in a deq cycle (branch is the dequeued instruction)
jump_target_i  input  PC_W  branch target
flush_i  input  1  discard everything, restart at flush_pc_i; overrides jump_i
flush_pc_i  input  PC_W  restart address
count_o  output  $clog2(DEPTH+1)  occupancy, for debug/perf counters

Behaviour:
- Reset (rst=0, async): rom_ce=0, rom_addr=RESET_PC, valid_o=0, pc_o=0, inst_o=0, count_o=0, inflight=0, redirect_pending=0. First rom_ce=1 occurs in the first cycle after rst deasserts.
- Issue rule: rom_ce=1 when count + inflight + (returning this cycle ? 0 : 0) < DEPTH, i.e. credits = DEPTH − count − inflight > 0. On issue, fetch_pc advances by PC_STEP (or to the redirect address, see below). At most one read in flight.
- Return: the cycle after an issue, {fetch address, rom_data} is enqueued unless cancelled. Enqueue and dequeue in the same cycle are allowed: count is unchanged. A full queue cannot be overrun by the credit rule.
- Output: valid_o = count≠0; pc_o/inst_o show the head entry directly from storage. No bypass: an instruction enqueued in cycle N is visible at the earliest in cycle N+1. Minimum latency from rom_ce to valid_o is 2 cycles.
- Wrap-around: read/write pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty are derived from count, not from pointer compare.
- jump_i (only counted when deq occurs and flush_i=0). The delay slot is the instruction at deq_pc+PC_STEP. Three cases:
  - (a) A second entry exists: keep it as the sole entry, drop all younger entries, cancel any in-flight read, next issue at jump_target_i.
  - (b) Queue holds only the branch, read in flight: keep the in-flight result (it is the delay slot), next issue at jump_target_i.
  - (c) Queue holds only the branch, nothing in flight: set redirect_pending. The next issue fetches deq_pc+PC_STEP, and the issue after that uses jump_target_i.
- flush_i: next cycle count=0, valid_o=0, the in-flight result is discarded, redirect_pending=0, and an issue at flush_pc_i occurs in the cycle after flush_i (rom_ce=1, rom_addr=flush_pc_i). flush_i and jump_i together: flush wins. flush_i while stall_i=1 is legal.
- stall_i=1 holds head outputs stable. Fetching continues until the queue is full.
- Reset asserted mid-operation clears everything immediately. In-flight data arriving after reset release is ignored (inflight cleared).
- Arithmetic: PC increment is modulo 2^PC_W. count never exceeds DEPTH; overflow/underflow is an assertion failure in simulation.

Decomposition:
- project_types gains fq_entry_t {pc_t pc; inst_t inst}, localparam FQ_DEPTH=4, and fq_count_t.
- Existing pc_t/inst_t are reused.
- One natural sub-module: fq_fifo. It is a parametrised circular buffer with push/pop/truncate-to-one, holds storage and pointers, and supports a "keep head+1 only" operation.
- Fetch control, credits, and redirect handling stay in fetch_queue.

Test Plan:
- Reset release, stall_i=0, ROM returns addr>>2:
  - rom_addr 0,4,8,... on consecutive cycles
  - valid_o first high cycle 2 with pc_o=0
  - one instruction/cycle thereafter
- stall_i=1 for 10 cycles:
  - exactly DEPTH=4 issues, count_o=4, rom_ce=0, pc_o frozen
  - releasing stall resumes with no lost/duplicated PC
- Jump case (a):
  - branch at pc 0x10 dequeued with jump_target_i=0x100, queue holding 0x14,0x18
  - next outputs 0x14 then 0x100; 0x18 never appears
- Jump case (c):
  - queue holds only 0x10, no read in flight, jump to 0x200
  - rom_addr sequence 0x14 then 0x200; output order 0x14, 0x200
- flush_i with flush_pc_i=0x380 asserted together with jump_i, queue full, read in flight:
  - next cycle valid_o=0, rom_addr=0x380
  - first output pc_o=0x380
- rst pulsed low mid-stream with a read in flight:
  - outputs return to reset values asynchronously
  - after release, first output pc_o=RESET_PC; no stale instruction
